// File: rtl/serial_magnitude_comparator_if.sv
// Handshake/operand/result bundle for serial_magnitude_comparator.
//   start         request, sampled only while the comparator is idle
//   A, B          WIDTH-bit operands, captured on an accepted start
//   busy          high while bits are being compared
//   done          one-cycle pulse when a result is registered
//   Y1, Y2, Y3    A > B, A == B, A < B (held until next result or reset)
//   cycles        bit-compare cycles used by the last operation
// Modports: master drives requests/operands, slave is the comparator.
interface serial_magnitude_comparator_if #(
  parameter int unsigned WIDTH = 8
) ();
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             Y1;
  logic             Y2;
  logic             Y3;
  logic [CW-1:0]    cycles;

  modport master (
    output start, A, B,
    input  busy, done, Y1, Y2, Y3, cycles
  );

  modport slave (
    input  start, A, B,
    output busy, done, Y1, Y2, Y3, cycles
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: captures A/B on start, compares MSB first
// one bit per clock, and registers Y1 (A>B) / Y2 (A==B) / Y3 (A<B) with a
// one-cycle done pulse.
// Ports: clk, rst (synchronous, active-high), bus (slave modport of
//   serial_magnitude_comparator_if: start, A, B, busy, done, Y1..Y3, cycles).
// Parameters: WIDTH (>= 2), EARLY_EXIT (1: stop at first differing bit).
// Build option: SIGNED_CMP_EN treats operands as two's complement by
//   inverting the sense of a difference found at the MSB.
module serial_magnitude_comparator #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input logic                          clk,
  input logic                          rst,
  serial_magnitude_comparator_if.slave bus
);
  localparam int unsigned   IW      = $clog2(WIDTH);
  localparam int unsigned   CW      = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic             diff_found;
  logic             diff_gt;

  logic bit_a;
  logic bit_b;
  logic differ;
  logic gt_bit;
  logic new_found;
  logic new_gt;
  logic last_bit;

  // Per-bit compare; the shift regs move left so the current bit is always the MSB.
  always_comb begin
    bit_a  = sa[WIDTH-1];
    bit_b  = sb[WIDTH-1];
    differ = bit_a ^ bit_b;
`ifdef SIGNED_CMP_EN
    // Sign bit: a set bit means the smaller value.
    gt_bit = (idx == IDX_TOP) ? (~bit_a & bit_b) : (bit_a & ~bit_b);
`else
    gt_bit = bit_a & ~bit_b;
`endif
    new_found = diff_found | differ;
    // Only the first (most significant) difference decides the result.
    new_gt    = diff_found ? diff_gt : gt_bit;
    last_bit  = (EARLY_EXIT & differ) | (idx == '0);
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      idx        <= '0;
      cnt        <= '0;
      diff_found <= 1'b0;
      diff_gt    <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.Y1     <= 1'b0;
      bus.Y2     <= 1'b0;
      bus.Y3     <= 1'b0;
      bus.cycles <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa         <= bus.A;
            sb         <= bus.B;
            idx        <= IDX_TOP;
            cnt        <= '0;
            diff_found <= 1'b0;
            diff_gt    <= 1'b0;
            bus.busy   <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            bus.Y1     <= new_found & new_gt;
            bus.Y2     <= ~new_found;
            bus.Y3     <= new_found & ~new_gt;
            bus.cycles <= cnt + CW'(1);
            bus.done   <= 1'b1;
            bus.busy   <= 1'b0;
            state      <= IDLE;
          end else begin
            sa         <= {sa[WIDTH-2:0], 1'b0};
            sb         <= {sb[WIDTH-2:0], 1'b0};
            idx        <= idx - IW'(1);
            cnt        <= cnt + CW'(1);
            diff_found <= new_found;
            diff_gt    <= new_gt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench: an early-exit and a full-scan comparator share one
// stimulus stream and are checked against an arithmetic reference model.
module tb_serial_magnitude_comparator;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [2:0] last_y;

  serial_magnitude_comparator_if #(.WIDTH(W)) bus_e ();
  serial_magnitude_comparator_if #(.WIDTH(W)) bus_f ();

  serial_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_e (
    .clk (clk),
    .rst (rst),
    .bus (bus_e)
  );

  serial_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_f (
    .clk (clk),
    .rst (rst),
    .bus (bus_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: relation from plain (signed or unsigned) arithmetic.
  function automatic logic [2:0] exp_y(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SIGNED_CMP_EN
    if ($signed(a) > $signed(b)) return 3'b100;
    if ($signed(a) < $signed(b)) return 3'b001;
`else
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
`endif
    return 3'b010;
  endfunction

  // Early-exit latency: position of the most significant differing bit.
  function automatic int exp_lat_early(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    x = a ^ b;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i]) return W - i;
    end
    return W;
  endfunction

  task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    bus_e.start = s; bus_e.A = a; bus_e.B = b;
    bus_f.start = s; bus_f.A = a; bus_f.B = b;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy_e"}, 32'(bus_e.busy), 0);
    check({tag, "_done_e"}, 32'(bus_e.done), 0);
    check({tag, "_y_e"}, 32'({bus_e.Y1, bus_e.Y2, bus_e.Y3}), 0);
    check({tag, "_cyc_e"}, 32'(bus_e.cycles), 0);
    check({tag, "_busy_f"}, 32'(bus_f.busy), 0);
    check({tag, "_done_f"}, 32'(bus_f.done), 0);
    check({tag, "_y_f"}, 32'({bus_f.Y1, bus_f.Y2, bus_f.Y3}), 0);
    check({tag, "_cyc_f"}, 32'(bus_f.cycles), 0);
  endtask

  // Waits for both results; returns at the negedge where the later done is visible.
  task automatic collect(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    int le;
    int lf;
    int le_exp;
    logic [2:0] ey;
    ey     = exp_y(a, b);
    le_exp = exp_lat_early(a, b);
    le = -1;
    lf = -1;
    for (int k = 1; k <= int'(W) + 2 && (le < 0 || lf < 0); k++) begin
      @(negedge clk);
      if (inject && k == 2) drive(1'b1, 8'h00, 8'hFF);
      if (inject && k == 3) drive(1'b0, 8'h00, 8'hFF);
      if (le < 0 && bus_e.done === 1'b1) begin
        le = k;
        check("y_e", 32'({bus_e.Y1, bus_e.Y2, bus_e.Y3}), 32'(ey));
        check("cyc_e", 32'(bus_e.cycles), 32'(le_exp));
        check("idle_e", 32'(bus_e.busy), 0);
      end
      if (lf < 0 && bus_f.done === 1'b1) begin
        lf = k;
        check("y_f", 32'({bus_f.Y1, bus_f.Y2, bus_f.Y3}), 32'(ey));
        check("cyc_f", 32'(bus_f.cycles), W);
        check("idle_f", 32'(bus_f.busy), 0);
      end
    end
    check("lat_e", 32'(le), 32'(le_exp));
    check("lat_f", 32'(lf), W);
    last_y = ey;
  endtask

  // Called at a negedge; a start here may coincide with a done cycle.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    drive(1'b1, a, b);
    @(negedge clk);
    drive(1'b0, a, b);
    check("start_busy_e", 32'(bus_e.busy), 1);
    check("start_busy_f", 32'(bus_f.busy), 1);
    check("pulse_done_e", 32'(bus_e.done), 0);
    check("pulse_done_f", 32'(bus_f.done), 0);
    collect(a, b, inject);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int   seen_done;
    n_vec  = 0;
    n_err  = 0;
    last_y = 3'b000;
    rst    = 1'b1;
    drive(1'b0, '0, '0);
    repeat (2) @(negedge clk);
    check_reset_state("rst");
    rst = 1'b0;
    @(negedge clk);

    launch(8'h80, 8'h7F, 1'b0);
    launch(8'h5A, 8'h5A, 1'b0);
    launch(8'h12, 8'h13, 1'b0);
    // Start pulsed with new operands mid-operation must be ignored.
    launch(8'h10, 8'h01, 1'b1);

    // Results hold while idle.
    repeat (3) @(negedge clk);
    check("hold_y_e", 32'({bus_e.Y1, bus_e.Y2, bus_e.Y3}), 32'(last_y));
    check("hold_y_f", 32'({bus_f.Y1, bus_f.Y2, bus_f.Y3}), 32'(last_y));
    check("hold_cyc_f", 32'(bus_f.cycles), W);

    // Reset mid-operation aborts with no done pulse.
    drive(1'b1, 8'h33, 8'h33);
    @(negedge clk);
    drive(1'b0, 8'h33, 8'h33);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b0;
    seen_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_e.done === 1'b1 || bus_f.done === 1'b1) seen_done++;
    end
    check("midrst_no_done", 32'(seen_done), 0);

    // Randomized operands: free, equal, or differing in one bit.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      case ($urandom_range(2, 0))
        0:       rb = W'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (W'(1) << $urandom_range(W - 1, 0));
      endcase
      if ($urandom_range(3, 0) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
      launch(ra, rb, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
